// File: rtl/spi_ram_burst_slave.sv
// SPI slave with an embedded single-port RAM and burst access: one command and start
// address per frame, then back-to-back data words with an auto-incrementing, wrapping address.
module spi_ram_burst_slave #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH  = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO,
  output logic busy,
  output logic frame_abort
);

  localparam int unsigned DW    = DATA_WIDTH;
  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned MAX_W = (AW > DW) ? AW : DW;
  localparam int unsigned CW    = $clog2(MAX_W + 1);
  localparam int unsigned MW    = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [CW-1:0] ADDR_LAST = CW'(AW - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DW - 1);
  localparam logic [AW-1:0] MEM_LAST  = AW'(MEM_DEPTH - 1);
  localparam logic [AW:0]   DEPTH_X   = (AW + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_WR_DATA, S_RD_WAIT, S_RD_DATA, S_IGNORE
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      cmd_q, cmd_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   sh_q, sh_d;
  logic [DW-1:0]   rd_buf_q, rd_buf_d;
  logic [DW-1:0]   wr_word_q, wr_word_d;
  logic            wr_pend_q, wr_pend_d;
  logic            miso_q, miso_d;
  logic            busy_q, busy_d;
  logic            abort_q, abort_d;

  logic [DW-1:0]   mem [MEM_DEPTH];
  logic            in_range_c;
  logic [MW-1:0]   mem_idx_c;
  logic [DW-1:0]   rdata_c;
  logic [AW-1:0]   addr_inc_c;

  // Out-of-range addresses still count but never touch the array.
  assign in_range_c = ({1'b0, addr_q} < DEPTH_X);
  assign mem_idx_c  = addr_q[MW-1:0];
  assign rdata_c    = in_range_c ? mem[mem_idx_c] : '0;
  assign addr_inc_c = (addr_q == MEM_LAST) ? '0 : addr_q + AW'(1);

  // Completed write words land one edge after their last bit, even if the frame ends there.
  always_ff @(posedge clk) begin
    if (wr_pend_q && in_range_c) mem[mem_idx_c] <= wr_word_q;
  end

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    rd_buf_d  = rd_buf_q;
    wr_word_d = wr_word_q;
    wr_pend_d = 1'b0;
    miso_d    = 1'b0;
    abort_d   = 1'b0;

    if (wr_pend_q) addr_d = addr_inc_c;

    if (SS_n) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      abort_d = (state_q inside {S_CMD, S_ADDR, S_RD_WAIT}) ||
                ((state_q == S_WR_DATA) && (cnt_q != '0));
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cmd_d   = {1'b0, MOSI};
          state_d = S_CMD;
        end
        S_CMD: begin
          cmd_d   = {cmd_q[0], MOSI};
          cnt_d   = '0;
          state_d = S_ADDR;
        end
        S_ADDR: begin
          addr_d = AW'({addr_q, MOSI});
          if (cnt_q == ADDR_LAST) begin
            cnt_d = '0;
            unique case (cmd_q)
              2'b00:   state_d = S_WR_DATA;
              2'b01:   state_d = S_RD_WAIT;
              default: state_d = S_IGNORE;
            endcase
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_WR_DATA: begin
          sh_d = {sh_q[DW-2:0], MOSI};
          if (cnt_q == DATA_LAST) begin
            cnt_d     = '0;
            wr_word_d = {sh_q[DW-2:0], MOSI};
            wr_pend_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        // First edge fetches mem[A]; second edge presents its MSB and prefetches A+1.
        S_RD_WAIT: begin
          rd_buf_d = rdata_c;
          addr_d   = addr_inc_c;
          if (cnt_q == '0) begin
            cnt_d = CW'(1);
          end else begin
            cnt_d   = '0;
            sh_d    = rd_buf_q;
            miso_d  = rd_buf_q[DW-1];
            state_d = S_RD_DATA;
          end
        end
        S_RD_DATA: begin
          if (cnt_q == DATA_LAST) begin
            cnt_d    = '0;
            sh_d     = rd_buf_q;
            miso_d   = rd_buf_q[DW-1];
            rd_buf_d = rdata_c;
            addr_d   = addr_inc_c;
          end else begin
            cnt_d  = cnt_q + CW'(1);
            sh_d   = sh_q << 1;
            miso_d = sh_q[DW-2];
          end
        end
        S_IGNORE: ;
        default: state_d = S_IDLE;
      endcase
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cmd_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      rd_buf_q  <= '0;
      wr_word_q <= '0;
      wr_pend_q <= 1'b0;
      miso_q    <= 1'b0;
      busy_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      rd_buf_q  <= rd_buf_d;
      wr_word_q <= wr_word_d;
      wr_pend_q <= wr_pend_d;
      miso_q    <= miso_d;
      busy_q    <= busy_d;
      abort_q   <= abort_d;
    end
  end

  assign MISO        = miso_q;
  assign busy        = busy_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_ram_burst_slave.sv
// Directed bench for spi_ram_burst_slave: default instance (8/8/256) and a 16/4/10 instance.
module tb_spi_ram_burst_slave;

  logic clk, rst_n, ss_a, ss_b, mosi;
  logic miso_a, busy_a, abort_a, miso_b, busy_b, abort_b;
  int   total = 0;
  int   bad   = 0;
  bit   sel   = 1'b0;

  spi_ram_burst_slave u_dut_a (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_a), .MOSI(mosi),
    .MISO(miso_a), .busy(busy_a), .frame_abort(abort_a)
  );

  spi_ram_burst_slave #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .MEM_DEPTH(10)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .SS_n(ss_b), .MOSI(mosi),
    .MISO(miso_b), .busy(busy_b), .frame_abort(abort_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic get_miso();  return sel ? miso_b  : miso_a;  endfunction
  function automatic logic get_busy();  return sel ? busy_b  : busy_a;  endfunction
  function automatic logic get_abort(); return sel ? abort_b : abort_a; endfunction

  task automatic set_ss(input logic v);
    if (sel) ss_b = v; else ss_a = v;
  endtask

  task automatic drive_bits(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      @(negedge clk);
      set_ss(1'b0);
      mosi = v[i];
    end
  endtask

  // SS_n rises the edge after the last driven bit; checks the outcome one cycle later.
  task automatic end_frame(input string tag, input logic exp_abort);
    @(negedge clk);
    set_ss(1'b1);
    mosi = 1'b0;
    @(negedge clk);
    check({tag, "_abort"}, get_abort(), exp_abort);
    check({tag, "_busy"},  get_busy(),  1'b0);
    check({tag, "_miso"},  get_miso(),  1'b0);
    @(negedge clk);
    check({tag, "_abort_gone"}, get_abort(), 1'b0);
  endtask

  task automatic wr_frame(input string tag, input int aw, input int dw, input logic [31:0] addr,
                          input logic [31:0] w0, input logic [31:0] w1, input int n);
    drive_bits(32'd0, 2);
    drive_bits(addr, aw);
    drive_bits(w0, dw);
    if (n > 1) drive_bits(w1, dw);
    end_frame(tag, 1'b0);
  endtask

  task automatic rd_frame(input string tag, input int aw, input int dw, input logic [31:0] addr,
                          input int n, output logic [31:0] r0, output logic [31:0] r1);
    logic pre;
    drive_bits(32'd1, 2);
    drive_bits(addr, aw);
    @(negedge clk);
    pre = get_miso();
    @(negedge clk);
    pre = pre | get_miso();
    check({tag, "_pre_miso"}, pre, 1'b0);
    check({tag, "_busy"}, get_busy(), 1'b1);
    r0 = '0;
    r1 = '0;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < dw; b++) begin
        @(negedge clk);
        if (w == 0) r0 = {r0[30:0], get_miso()};
        else        r1 = {r1[30:0], get_miso()};
      end
    end
    end_frame(tag, 1'b0);
  endtask

  logic [31:0] r0, r1;
  logic        acc;

  initial begin
    rst_n = 1'b0;
    ss_a  = 1'b1;
    ss_b  = 1'b1;
    mosi  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_miso_a", miso_a, 1'b0);
    check("rst_busy_a", busy_a, 1'b0);
    check("rst_abort_a", abort_a, 1'b0);
    check("rst_miso_b", miso_b, 1'b0);
    check("rst_busy_b", busy_b, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Write then read back with no inter-word gap.
    wr_frame("wr10", 8, 8, 32'h10, 32'hA5, 32'h3C, 2);
    rd_frame("rd10", 8, 8, 32'h10, 2, r0, r1);
    check("rd10_w0", r0, 32'hA5);
    check("rd10_w1", r1, 32'h3C);

    // Address wrap at the top of the array.
    wr_frame("wrFF", 8, 8, 32'hFF, 32'h11, 32'h22, 2);
    rd_frame("rdFF", 8, 8, 32'hFF, 2, r0, r1);
    check("rdFF_w0", r0, 32'h11);
    check("rdFF_w1", r1, 32'h22);
    rd_frame("rd00", 8, 8, 32'h00, 1, r0, r1);
    check("rd00_w0", r0, 32'h22);

    // Aborts: partial word, partial cmd, partial addr, read before first data.
    wr_frame("wr20", 8, 8, 32'h20, 32'h5A, 32'h0, 1);
    drive_bits(32'd0, 2);
    drive_bits(32'h20, 8);
    drive_bits(32'h15, 5);
    end_frame("ab_wr", 1'b1);
    rd_frame("rd20", 8, 8, 32'h20, 1, r0, r1);
    check("rd20_kept", r0, 32'h5A);
    drive_bits(32'd0, 1);
    end_frame("ab_cmd", 1'b1);
    drive_bits(32'd1, 2);
    drive_bits(32'h5, 3);
    end_frame("ab_addr", 1'b1);
    drive_bits(32'd1, 2);
    drive_bits(32'h10, 8);
    end_frame("ab_rdwait", 1'b1);

    // Reserved command: MISO stays low and RAM is untouched.
    drive_bits(32'd3, 2);
    drive_bits(32'h10, 8);
    acc = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mosi = 1'b1;
      acc = acc | get_miso();
    end
    check("ign_miso", acc, 1'b0);
    end_frame("ign", 1'b0);
    rd_frame("rd10b", 8, 8, 32'h10, 1, r0, r1);
    check("rd10b_w0", r0, 32'hA5);

    // Asynchronous reset while shifting out read data.
    drive_bits(32'd1, 2);
    drive_bits(32'h10, 8);
    repeat (3) @(negedge clk);
    check("rst_rd_miso_before", miso_a, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_rd_miso", miso_a, 1'b0);
    check("rst_rd_busy", busy_a, 1'b0);
    @(negedge clk);
    ss_a  = 1'b1;
    rst_n = 1'b1;
    @(negedge clk);
    rd_frame("rd10c", 8, 8, 32'h10, 1, r0, r1);
    check("rd10c_w0", r0, 32'hA5);

    // Wide-data, shallow-array instance.
    sel = 1'b1;
    wr_frame("b_wr9", 4, 16, 32'h9, 32'hBEEF, 32'h1234, 2);
    rd_frame("b_rd9", 4, 16, 32'h9, 2, r0, r1);
    check("b_rd9_w0", r0, 32'hBEEF);
    check("b_rd9_w1", r1, 32'h1234);
    rd_frame("b_rd0", 4, 16, 32'h0, 1, r0, r1);
    check("b_rd0_w0", r0, 32'h1234);
    wr_frame("b_wr12", 4, 16, 32'hC, 32'hCAFE, 32'h0, 1);
    rd_frame("b_rd12", 4, 16, 32'hC, 1, r0, r1);
    check("b_rd12_w0", r0, 32'h0000);
    rd_frame("b_rd9b", 4, 16, 32'h9, 1, r0, r1);
    check("b_rd9b_w0", r0, 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
